// File: rtl/systolic_array_ctrl.sv
// Self-sequencing output-stationary NxN systolic MAC array with skewed operand feed.
// Build option: SYSTOLIC_ACC_SAT_EN selects saturating accumulators.
module systolic_array_ctrl #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_W    = 16
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic                   i_start,
  input  logic [K_W-1:0]         i_k,
  output logic                   o_busy,
  input  logic                   i_ab_valid,
  output logic                   o_ab_ready,
  input  logic [N*DATA_W-1:0]    i_a,
  input  logic [N*DATA_W-1:0]    i_b,
  output logic                   o_c_valid,
  input  logic                   i_c_ready,
  output logic [N*ACC_W-1:0]     o_c,
  output logic [$clog2(N)-1:0]   o_c_row,
  output logic                   o_done
);

  localparam int RW = $clog2(N);
  localparam int FW = $clog2(2*N);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t         state;
  logic [K_W-1:0] k_left;
  logic [FW-1:0]  fl_cnt;
  logic           clr;
  logic           en;

  logic signed [DATA_W-1:0] a_src [N];
  logic signed [DATA_W-1:0] b_src [N];
  logic signed [DATA_W-1:0] a_sk  [N];
  logic signed [DATA_W-1:0] b_sk  [N];
  logic signed [DATA_W-1:0] a_pe  [N][N];
  logic signed [DATA_W-1:0] b_pe  [N][N];
  logic signed [DATA_W-1:0] a_in  [N][N];
  logic signed [DATA_W-1:0] b_in  [N][N];
  logic signed [ACC_W-1:0]  acc   [N][N];

  assign clr = (state == IDLE) && i_start;
  assign en  = ((state == LOAD) && i_ab_valid) || (state == FLUSH);

  function automatic logic signed [ACC_W-1:0] mac(
    input logic signed [ACC_W-1:0]  s,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] p;
`ifdef SYSTOLIC_ACC_SAT_EN
    logic signed [ACC_W:0] t;
    p = a * b;
    t = (ACC_W+1)'(s) + (ACC_W+1)'(p);
    if (t[ACC_W] != t[ACC_W-1])
      mac = t[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                     : {1'b0, {(ACC_W-1){1'b1}}};
    else
      mac = t[ACC_W-1:0];
`else
    p = a * b;
    mac = s + ACC_W'(p);
`endif
  endfunction

  // Zeros are fed in FLUSH so the wavefront drains cleanly.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_src[i] = (state == LOAD) ? i_a[i*DATA_W +: DATA_W] : '0;
      b_src[i] = (state == LOAD) ? i_b[i*DATA_W +: DATA_W] : '0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_d0
      assign a_sk[i] = a_src[i];
      assign b_sk[i] = b_src[i];
    end else begin : g_dn
      logic signed [DATA_W-1:0] da [i];
      logic signed [DATA_W-1:0] db [i];
      always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
          for (int d = 0; d < i; d++) begin
            da[d] <= '0;
            db[d] <= '0;
          end
        end else if (clr) begin
          for (int d = 0; d < i; d++) begin
            da[d] <= '0;
            db[d] <= '0;
          end
        end else if (en) begin
          da[0] <= a_src[i];
          db[0] <= b_src[i];
          for (int d = 1; d < i; d++) begin
            da[d] <= da[d-1];
            db[d] <= db[d-1];
          end
        end
      end
      assign a_sk[i] = da[i-1];
      assign b_sk[i] = db[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = a_sk[i];
      b_in[0][i] = b_sk[i];
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = a_pe[i][j-1];
        b_in[j][i] = b_pe[j-1][i];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n || clr) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_pe[i][j] <= '0;
          b_pe[i][j] <= '0;
          acc[i][j]  <= '0;
        end
    end else if (en) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          a_pe[i][j] <= a_in[i][j];
          b_pe[i][j] <= b_in[i][j];
          acc[i][j]  <= mac(acc[i][j], a_in[i][j], b_in[i][j]);
        end
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++)
      o_c[j*ACC_W +: ACC_W] = acc[o_c_row][j];
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state      <= IDLE;
      k_left     <= '0;
      fl_cnt     <= '0;
      o_c_row    <= '0;
      o_busy     <= 1'b0;
      o_ab_ready <= 1'b0;
      o_c_valid  <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            o_busy <= 1'b1;
            k_left <= i_k;
            fl_cnt <= '0;
            if (i_k == '0) begin
              state <= FLUSH;
            end else begin
              state      <= LOAD;
              o_ab_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (i_ab_valid) begin
            k_left <= k_left - 1'b1;
            if (k_left == K_W'(1)) begin
              state      <= FLUSH;
              o_ab_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          fl_cnt <= fl_cnt + 1'b1;
          if (fl_cnt == FW'(2*N-2)) begin
            state     <= DRAIN;
            o_c_valid <= 1'b1;
            o_c_row   <= '0;
          end
        end
        DRAIN: begin
          if (i_c_ready) begin
            if (o_c_row == RW'(N-1)) begin
              state     <= IDLE;
              o_c_valid <= 1'b0;
              o_busy    <= 1'b0;
              o_done    <= 1'b1;
              o_c_row   <= '0;
            end else begin
              o_c_row <= o_c_row + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Randomized self-checking bench for systolic_array_ctrl.
// Reference: C = sum over beats of outer(A, B), computed with plain integers.
module tb_systolic_array_ctrl;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int KW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start, busy, ab_valid, ab_ready;
  logic [KW-1:0]   k;
  logic [N*DW-1:0] a_vec, b_vec;
  logic            c_valid, c_ready, done;
  logic [N*AW-1:0] c_vec;
  logic [2:0]      c_row;

  logic            s_start, s_busy, s_abv, s_abr;
  logic [KW-1:0]   s_k;
  logic [15:0]     s_a, s_b;
  logic            s_cv, s_cr, s_row, s_done;
  logic [31:0]     s_c;

  int checks = 0;
  int errors = 0;
  int ma [64][N];
  int mb [64][N];

  systolic_array_ctrl #(.N(N), .DATA_W(DW), .ACC_W(AW), .K_W(KW)) dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_start(start), .i_k(k),
    .o_busy(busy), .i_ab_valid(ab_valid), .o_ab_ready(ab_ready),
    .i_a(a_vec), .i_b(b_vec), .o_c_valid(c_valid), .i_c_ready(c_ready),
    .o_c(c_vec), .o_c_row(c_row), .o_done(done)
  );

  systolic_array_ctrl #(.N(2), .DATA_W(8), .ACC_W(16), .K_W(KW)) dut_w16 (
    .i_clk(clk), .i_arst_n(rst_n), .i_start(s_start), .i_k(s_k),
    .o_busy(s_busy), .i_ab_valid(s_abv), .o_ab_ready(s_abr),
    .i_a(s_a), .i_b(s_b), .o_c_valid(s_cv), .i_c_ready(s_cr),
    .o_c(s_c), .o_c_row(s_row), .o_done(s_done)
  );

  task automatic check(input string tag, input logic [N*AW-1:0] got,
                       input logic [N*AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int mode, input bit is_b);
    case (mode)
      0:       return 1;
      1:       return -128;
      2:       return is_b ? 127 : -128;
      default: return int'($urandom_range(255)) - 128;
    endcase
  endfunction

  function automatic logic [N*AW-1:0] model_row(input int kk, input int r);
    logic [N*AW-1:0] v;
    longint s;
    v = '0;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int b = 0; b < kk; b++)
        s += longint'(ma[b][r]) * longint'(mb[b][j]);
      v[j*AW +: AW] = s[AW-1:0];
    end
    return v;
  endfunction

  task automatic run_op(input int kk, input int mode, input bit rv,
                        input bit cs, input bit sf);
    int beats = 0;
    int cyc = 0;
    int lim;
    bit saw = 1'b0;
    bit sent = 1'b0;
    for (int b = 0; b < kk; b++)
      for (int j = 0; j < N; j++) begin
        ma[b][j] = pick(mode, 1'b0);
        mb[b][j] = pick(mode, 1'b1);
      end
    lim = kk * 4 + 64;
    start = 1'b1;
    k = KW'(kk);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (beats < kk && cyc < lim) begin
      ab_valid = rv ? 1'($urandom_range(1)) : 1'b1;
      for (int j = 0; j < N; j++) begin
        a_vec[j*DW +: DW] = DW'(ma[beats][j]);
        b_vec[j*DW +: DW] = DW'(mb[beats][j]);
      end
      if (ab_valid && ab_ready) beats++;
      @(posedge clk); #1;
      cyc++;
    end
    ab_valid = 1'b0;
    if (beats < kk) check("load_timeout", beats, kk);
    while (!c_valid && cyc < lim) begin
      if (sf && !sent) begin
        start = 1'b1;
        k = KW'(5);
        sent = 1'b1;
      end else begin
        start = 1'b0;
      end
      saw |= ab_ready;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("ready_in_flush", saw, 0);
    check("c_valid_seen", c_valid, 1);
    if (!rv) check("latency", cyc, 1 + kk + 2*N - 1);
    for (int r = 0; r < N; r++) begin
      if (cs && (r == 2 || r == 5)) begin
        c_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          check("stall_row", c_row, r);
          check("stall_data", c_vec, model_row(kk, r));
        end
      end
      c_ready = 1'b1;
      check("row_idx", c_row, r);
      check("row_data", c_vec, model_row(kk, r));
      @(posedge clk); #1;
    end
    c_ready = 1'b0;
    check("done", done, 1);
    check("valid_drop", c_valid, 0);
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("idle", busy, 0);
  endtask

  initial begin
    int e;
    int cyc;
    start = 1'b0; k = '0; ab_valid = 1'b0;
    a_vec = '0; b_vec = '0; c_ready = 1'b0;
    s_start = 1'b0; s_k = '0; s_abv = 1'b0;
    s_a = '0; s_b = '0; s_cr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", {busy, ab_ready, c_valid, done}, 0);
    check("rst_c", c_vec, 0);
    check("rst_row", c_row, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8, 0, 1'b0, 1'b0, 1'b0);
    run_op(4, 1, 1'b0, 1'b0, 1'b0);
    run_op(4, 2, 1'b0, 1'b0, 1'b0);
    run_op(16, 3, 1'b1, 1'b1, 1'b0);
    run_op(0, 0, 1'b0, 1'b0, 1'b0);
    run_op(8, 0, 1'b0, 1'b0, 1'b0);

    start = 1'b1;
    k = KW'(8);
    @(posedge clk); #1;
    start = 1'b0;
    ab_valid = 1'b1;
    for (int j = 0; j < N; j++) begin
      a_vec[j*DW +: DW] = 8'd3;
      b_vec[j*DW +: DW] = 8'd5;
    end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_flags", {busy, ab_ready, c_valid, done}, 0);
    check("arst_c", c_vec, 0);
    check("arst_row", c_row, 0);
    ab_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8, 0, 1'b0, 1'b0, 1'b1);

    e = 3 * 127 * 127;
`ifdef SYSTOLIC_ACC_SAT_EN
    if (e > 32767) e = 32767;
`endif
    s_start = 1'b1;
    s_k = KW'(3);
    @(posedge clk); #1;
    s_start = 1'b0;
    s_abv = 1'b1;
    s_a = {2{8'sd127}};
    s_b = {2{8'sd127}};
    repeat (3) @(posedge clk);
    #1;
    s_abv = 1'b0;
    cyc = 0;
    while (!s_cv && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("w16_valid", s_cv, 1);
    s_cr = 1'b1;
    for (int r = 0; r < 2; r++) begin
      check("w16_row", s_row, r);
      check("w16_data", s_c, {e[15:0], e[15:0]});
      @(posedge clk); #1;
    end
    s_cr = 1'b0;
    check("w16_done", s_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
